instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter NB_BYTE, default 8, meaning width of one received byte.
REQ-002 The block SHALL have parameter NB_DATA, default 32, meaning instruction word width (4 bytes).
REQ-003 The block SHALL have parameter NB_ADDR, default 8, meaning instruction-memory word-address width (256 words).
REQ-004 The block SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, meaning the terminating instruction.
REQ-005 The block SHALL have port i_clock  input  1  system clock, all logic on rising edge.
REQ-006 The block SHALL have port i_reset  input  1  reset, synchronous, active-low.
REQ-007 The block SHALL have port i_enable  input  1  load enable; bytes are accepted only while high.
REQ-008 The block SHALL have port i_rx_data  input  NB_BYTE  received byte from the UART receiver.
REQ-009 The block SHALL have port i_rx_done  input  1  one-cycle strobe marking i_rx_data valid.
REQ-010 The block SHALL have port o_wr_en  output  1  one-cycle instruction-memory write strobe.
REQ-011 The block SHALL have port o_wr_addr  output  NB_ADDR  word address of the write.
REQ-012 The block SHALL have port o_wr_data  output  NB_DATA  assembled instruction word.
REQ-013 The block SHALL have port o_word_count  output  NB_ADDR+1  number of words written so far.
REQ-014 The block SHALL have port o_done  output  1  high, and held high, once loading has terminated.

Function
REQ-015 The FSM SHALL have states IDLE, LOADING and DONE.
REQ-016 In IDLE, i_enable high SHALL move the FSM to LOADING on the next edge; no byte is consumed in that cycle.
REQ-017 In LOADING, each cycle with i_rx_done=1 and i_enable=1 SHALL shift i_rx_data into a 32-bit assembly register, first byte received becoming bits [31:24] (big-endian).
REQ-018 A 2-bit byte counter SHALL increment per accepted byte and wrap 3->0.
REQ-019 On acceptance of the 4th byte, o_wr_en SHALL be 1 in the following cycle only, with o_wr_data equal to the assembled word and o_wr_addr equal to the current word pointer (latency 1 cycle from the 4th strobe).
REQ-020 The word pointer and o_word_count SHALL increment in the same cycle o_wr_en is high.
REQ-021 A byte strobe arriving in the o_wr_en cycle SHALL be accepted as byte 0 of the next word; no byte SHALL be lost at back-to-back strobes.
REQ-022 If the written word equals HALT_WORD, the FSM SHALL enter DONE after that write; the HALT_WORD itself SHALL be written.
REQ-023 If the write targets address 2^NB_ADDR-1, the FSM SHALL enter DONE after that write; the pointer SHALL NOT wrap.
REQ-024 In LOADING, i_enable low SHALL freeze all state (partial word retained); strobes are ignored.
REQ-025 In DONE, o_done SHALL be 1, o_wr_en SHALL be 0, and all strobes SHALL be ignored until reset.
REQ-026 o_wr_addr and o_wr_data SHALL hold their last written values between writes.

Reset
REQ-027 With i_reset=0 at a rising edge, the FSM SHALL enter IDLE and o_wr_en, o_wr_addr, o_wr_data, o_word_count, o_done, the byte counter and the assembly register SHALL all be 0.
REQ-028 Reset mid-word or mid-write SHALL discard the partial word and suppress any pending o_wr_en.

Structure
REQ-029 NB_BYTE, NB_DATA, NB_ADDR, HALT_WORD and the state encodings SHALL live in the shared pipeline package alongside the opcode constants.
REQ-030 The byte assembler (shift register plus byte counter) SHALL be the one sub-module, named byte_assembler; the FSM and pointer stay in the top.

Verification
REQ-031 Reset, enable, bytes 0x20,0x08,0x00,0x05 -> one o_wr_en pulse, addr 0, data 32'h2008_0005, word_count 1.
REQ-032 Two words streamed with i_rx_done high on consecutive cycles across the write cycle -> addr 0 and 1 written with correct data, no byte dropped.
REQ-033 Word 0x0000_0000 then 0xFF,0xFF,0xFF,0xFF -> HALT written at addr 1, o_done=1, later strobes cause no writes.
REQ-034 256 non-HALT words -> last write at addr 255, o_done=1, word_count 256, no write to addr 0 after.
REQ-035 i_reset low after 2 bytes, then 4 new bytes -> first write at addr 0 containing only the 4 new bytes.
REQ-036 i_enable low between bytes 2 and 3 with strobes pulsed -> strobes ignored, word completes correctly after re-enable.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared pipeline definitions: loader sizing, halt word, loader FSM states
// and the opcode constants used by the decode stage.
package instruction_loader_pkg;

  localparam int NB_BYTE = 8;
  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 8;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADING = 2'd1,
    ST_DONE    = 2'd2
  } loader_state_e;

  // Primary opcode field values (instr[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// Big-endian byte assembler: shifts accepted bytes into a word register and
// flags the byte that completes a word. o_word is the word including the
// byte currently being shifted in, so the caller can capture it on that edge.
module byte_assembler #(
  parameter int NB_BYTE = 8,
  parameter int NB_DATA = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_shift,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic               o_last,
  output logic [NB_DATA-1:0] o_word
);

  localparam logic [1:0] LAST_CNT = 2'(NB_DATA / NB_BYTE - 1);

  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [1:0]         cnt_q, cnt_d;

  // Next shift/count values; the oldest byte falls off the top
  always_comb begin
    o_word  = (shift_q << NB_BYTE) | NB_DATA'(i_byte);
    o_last  = i_shift && (cnt_q == LAST_CNT);
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (i_shift) begin
      shift_d = o_word;
      cnt_d   = cnt_q + 2'd1;
    end
  end

  // Register update with synchronous active-low reset
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Instruction loader: assembles UART bytes into words and writes them to
// instruction memory until a halt word is written or memory is full.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for i_enable; no bytes consumed
// ST_LOADING | accepting bytes, issuing one write per 4 bytes
// ST_DONE    | loading terminated; o_done held, strobes ignored until reset
module instruction_loader #(
  parameter int                       NB_BYTE   = instruction_loader_pkg::NB_BYTE,
  parameter int                       NB_DATA   = instruction_loader_pkg::NB_DATA,
  parameter int                       NB_ADDR   = instruction_loader_pkg::NB_ADDR,
  parameter logic [NB_DATA-1:0]       HALT_WORD = instruction_loader_pkg::HALT_WORD
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic               o_wr_en,
  output logic [NB_ADDR-1:0] o_wr_addr,
  output logic [NB_DATA-1:0] o_wr_data,
  output logic [NB_ADDR:0]   o_word_count,
  output logic               o_done
);

  import instruction_loader_pkg::*;

  localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

  loader_state_e      state_q, state_d;
  logic               wr_en_q, wr_en_d;
  logic               term_q, term_d;
  logic [NB_ADDR-1:0] ptr_q, ptr_d;
  logic [NB_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [NB_DATA-1:0] wr_data_q, wr_data_d;
  logic [NB_ADDR:0]   count_q, count_d;

  logic               accept;
  logic               word_last;
  logic [NB_DATA-1:0] word_full;

  // A byte is taken only while loading and enabled. The write cycle of the
  // terminating word already belongs to DONE, so its strobe is dropped.
  assign accept = (state_q == ST_LOADING) && i_enable && i_rx_done &&
                  !(wr_en_q && term_q);

  byte_assembler #(
    .NB_BYTE (NB_BYTE),
    .NB_DATA (NB_DATA)
  ) u_byte_assembler (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_shift (accept),
    .i_byte  (i_rx_data),
    .o_last  (word_last),
    .o_word  (word_full)
  );

  // Next-state, write request and pointer bookkeeping
  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    term_d    = 1'b0;
    ptr_d     = ptr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    count_d   = count_q;
    case (state_q)
      ST_IDLE: begin
        if (i_enable) state_d = ST_LOADING;
      end
      ST_LOADING: begin
        if (wr_en_q && term_q) begin
          state_d = ST_DONE;
        end else if (word_last) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = word_full;
          count_d   = count_q + (NB_ADDR+1)'(1);
          term_d    = (word_full == HALT_WORD) || (ptr_q == LAST_ADDR);
          // Pointer saturates at the top address instead of wrapping
          if (ptr_q != LAST_ADDR) ptr_d = ptr_q + NB_ADDR'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q   <= ST_IDLE;
      wr_en_q   <= 1'b0;
      term_q    <= 1'b0;
      ptr_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      term_q    <= term_d;
      ptr_q     <= ptr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      count_q   <= count_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_word_count = count_q;
  assign o_done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: every write is captured and
// compared against a word list derived from the bytes the bench delivered.
module tb_instruction_loader;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        i_clock;
  logic        i_reset;
  logic        i_enable;
  logic [7:0]  i_rx_data;
  logic        i_rx_done;
  logic        o_wr_en;
  logic [7:0]  o_wr_addr;
  logic [31:0] o_wr_data;
  logic [8:0]  o_word_count;
  logic        o_done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  got_addr[$];
  logic [31:0] got_data[$];
  logic [7:0]  acc[$];
  logic [7:0]  exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_done;

  instruction_loader #(
    .NB_BYTE   (8),
    .NB_DATA   (32),
    .NB_ADDR   (8),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_rx_data    (i_rx_data),
    .i_rx_done    (i_rx_done),
    .o_wr_en      (o_wr_en),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_word_count (o_word_count),
    .o_done       (o_done)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  always @(negedge i_clock) begin
    if (o_wr_en) begin
      got_addr.push_back(o_wr_addr);
      got_data.push_back(o_wr_data);
    end
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset, then one enabled cycle to leave IDLE; all later enabled strobes count
  task automatic start();
    i_reset = 1'b0; i_enable = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00;
    idle(2);
    i_reset = 1'b1; i_enable = 1'b1;
    tick();
    got_addr.delete(); got_data.delete(); acc.delete();
  endtask

  task automatic send(input logic [7:0] b, input logic en);
    i_enable = en; i_rx_data = b; i_rx_done = 1'b1;
    tick();
    if (en) acc.push_back(b);
    i_rx_done = 1'b0; i_enable = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send(w[8*k +: 8], 1'b1);
  endtask

  // Reference: group delivered bytes big-endian, addresses from 0, stop after
  // the halt word or after the write to the last address.
  function automatic void model_words();
    int n;
    logic [31:0] w;
    exp_addr.delete(); exp_data.delete(); exp_done = 0;
    n = acc.size() / 4;
    for (int i = 0; i < n && !exp_done; i++) begin
      w = {acc[4*i], acc[4*i+1], acc[4*i+2], acc[4*i+3]};
      exp_addr.push_back(8'(i));
      exp_data.push_back(w);
      if (w == HALT || i == 255) exp_done = 1;
    end
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom();
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  task automatic test_reset();
    i_reset = 1'b0; i_enable = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00;
    idle(2);
    checks++; if (o_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", o_wr_en); end
    checks++; if (o_wr_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", o_wr_addr); end
    checks++; if (o_wr_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", o_wr_data); end
    checks++; if (o_word_count !== 9'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", o_word_count); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", o_done); end
  endtask

  task automatic test_basic();
    i_reset = 1'b0; idle(1);
    i_reset = 1'b1; i_enable = 1'b1;
    // strobe in the IDLE->LOADING cycle must not be consumed
    i_rx_data = 8'hAA; i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
    send(8'h20, 1'b1); idle(2);
    send(8'h08, 1'b1); idle(1);
    send(8'h00, 1'b1); idle(3);
    i_rx_data = 8'h05; i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
    checks++; if (o_wr_en !== 1'b1) begin errors++; $display("FAIL basic_wr_en got %b exp 1", o_wr_en); end
    checks++; if (o_wr_addr !== 8'h00) begin errors++; $display("FAIL basic_addr got %h exp 00", o_wr_addr); end
    checks++; if (o_wr_data !== 32'h2008_0005) begin errors++; $display("FAIL basic_data got %h exp 20080005", o_wr_data); end
    checks++; if (o_word_count !== 9'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", o_word_count); end
    tick();
    checks++; if (o_wr_en !== 1'b0) begin errors++; $display("FAIL basic_pulse_len got %b exp 0", o_wr_en); end
    checks++; if (o_wr_data !== 32'h2008_0005) begin errors++; $display("FAIL basic_data_hold got %h exp 20080005", o_wr_data); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL basic_done got %b exp 0", o_done); end
  endtask

  task automatic test_back_to_back();
    start();
    for (int k = 0; k < 3; k++) send_word(rand_word());
    idle(3);
    model_words();
    checks++; if (got_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL b2b_writes got %0d exp %0d", got_addr.size(), exp_addr.size()); end
    for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
      checks++;
      if ({got_addr[k], got_data[k]} !== {exp_addr[k], exp_data[k]}) begin
        errors++; $display("FAIL b2b_word%0d got %h:%h exp %h:%h", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
      end
    end
    checks++; if (o_word_count !== 9'd3) begin errors++; $display("FAIL b2b_count got %0d exp 3", o_word_count); end
  endtask

  task automatic test_halt();
    start();
    send_word(32'h0000_0000);
    send_word(HALT);
    for (int k = 0; k < 8; k++) send(8'($urandom()), 1'b1);
    idle(2);
    model_words();
    checks++; if (got_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL halt_writes got %0d exp %0d", got_addr.size(), exp_addr.size()); end
    for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
      checks++;
      if ({got_addr[k], got_data[k]} !== {exp_addr[k], exp_data[k]}) begin
        errors++; $display("FAIL halt_word%0d got %h:%h exp %h:%h", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
      end
    end
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL halt_done got %b exp 1", o_done); end
    checks++; if (o_word_count !== 9'd2) begin errors++; $display("FAIL halt_count got %0d exp 2", o_word_count); end
    checks++; if ({o_wr_addr, o_wr_data} !== {8'h01, HALT}) begin errors++; $display("FAIL halt_hold got %h:%h exp 01:ffffffff", o_wr_addr, o_wr_data); end
  endtask

  task automatic test_fill();
    start();
    for (int w = 0; w < 256; w++) begin
      logic [31:0] v;
      v = rand_word();
      for (int k = 3; k >= 0; k--) begin
        send(v[8*k +: 8], 1'b1);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    for (int k = 0; k < 8; k++) send(8'($urandom()), 1'b1);
    idle(2);
    model_words();
    checks++; if (got_addr.size() !== 256) begin errors++; $display("FAIL fill_writes got %0d exp 256", got_addr.size()); end
    for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
      checks++;
      if ({got_addr[k], got_data[k]} !== {exp_addr[k], exp_data[k]}) begin
        errors++; $display("FAIL fill_word%0d got %h:%h exp %h:%h", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
      end
    end
    checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL fill_done got %b exp 1", o_done); end
    checks++; if (o_word_count !== 9'd256) begin errors++; $display("FAIL fill_count got %0d exp 256", o_word_count); end
    checks++; if (o_wr_addr !== 8'hFF) begin errors++; $display("FAIL fill_last_addr got %h exp ff", o_wr_addr); end
  endtask

  task automatic test_reset_mid();
    start();
    // reset arriving with the 4th byte suppresses the write
    send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1);
    i_rx_data = 8'h44; i_rx_done = 1'b1; i_reset = 1'b0;
    tick();
    i_rx_done = 1'b0;
    checks++; if (o_wr_en !== 1'b0) begin errors++; $display("FAIL rstwr_wr_en got %b exp 0", o_wr_en); end
    checks++; if (o_word_count !== 9'd0) begin errors++; $display("FAIL rstwr_count got %0d exp 0", o_word_count); end
    i_reset = 1'b1; i_enable = 1'b1;
    tick();
    send(8'h55, 1'b1); send(8'h66, 1'b1);
    i_reset = 1'b0; tick();
    i_reset = 1'b1; tick();
    got_addr.delete(); got_data.delete(); acc.delete();
    send(8'hC1, 1'b1); send(8'hC2, 1'b1); send(8'hC3, 1'b1); send(8'hC4, 1'b1);
    idle(2);
    checks++; if (got_addr.size() !== 1) begin errors++; $display("FAIL rstmid_writes got %0d exp 1", got_addr.size()); end
    if (got_addr.size() > 0) begin
      checks++;
      if ({got_addr[0], got_data[0]} !== {8'h00, 32'hC1C2_C3C4}) begin
        errors++; $display("FAIL rstmid_word got %h:%h exp 00:c1c2c3c4", got_addr[0], got_data[0]);
      end
    end
  endtask

  task automatic test_enable_gap();
    start();
    send(8'h8A, 1'b1); send(8'h7B, 1'b1);
    for (int k = 0; k < 3; k++) send(8'($urandom()), 1'b0);
    i_enable = 1'b0; idle(2); i_enable = 1'b1;
    checks++; if (o_word_count !== 9'd0) begin errors++; $display("FAIL engap_count got %0d exp 0", o_word_count); end
    send(8'h6C, 1'b1); send(8'h5D, 1'b1);
    idle(2);
    checks++; if (got_addr.size() !== 1) begin errors++; $display("FAIL engap_writes got %0d exp 1", got_addr.size()); end
    if (got_addr.size() > 0) begin
      checks++;
      if ({got_addr[0], got_data[0]} !== {8'h00, 32'h8A7B_6C5D}) begin
        errors++; $display("FAIL engap_word got %h:%h exp 00:8a7b6c5d", got_addr[0], got_data[0]);
      end
    end
  endtask

  task automatic test_random_stream();
    start();
    for (int c = 0; c < 200; c++) begin
      if ($urandom_range(0, 2) != 0) send(8'($urandom()), ($urandom_range(0, 3) != 0));
      else idle(1);
    end
    idle(3);
    model_words();
    checks++; if (got_addr.size() !== exp_addr.size()) begin errors++; $display("FAIL rand_writes got %0d exp %0d", got_addr.size(), exp_addr.size()); end
    for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
      checks++;
      if ({got_addr[k], got_data[k]} !== {exp_addr[k], exp_data[k]}) begin
        errors++; $display("FAIL rand_word%0d got %h:%h exp %h:%h", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
      end
    end
    checks++; if (o_word_count !== 9'(exp_addr.size())) begin errors++; $display("FAIL rand_count got %0d exp %0d", o_word_count, exp_addr.size()); end
    checks++; if (o_done !== exp_done) begin errors++; $display("FAIL rand_done got %b exp %b", o_done, exp_done); end
  endtask

  initial begin
    i_reset = 1'b0; i_enable = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00;
    test_reset();
    test_basic();
    test_back_to_back();
    test_halt();
    test_fill();
    test_reset_mid();
    test_enable_gap();
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
